// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter giving NM Wishbone pipelined masters turns on one shared slave.
// Defining WB_ARB_TIMEOUT_EN adds a hung-slave timer that aborts the owner's cycle.
module wb_rr_arbiter #(
  parameter int NM      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NM-1:0]   m_cyc,
  input  logic [NM-1:0]   m_stb,
  input  logic [NM-1:0]   m_we,
  input  logic [32*NM-1:0] m_addr,
  input  logic [32*NM-1:0] m_data,
  input  logic [4*NM-1:0] m_sel,
  output logic [NM-1:0]   m_stall,
  output logic [NM-1:0]   m_ack,
  output logic [NM-1:0]   m_err,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [31:0]     o_addr,
  output logic [31:0]     o_data,
  output logic [3:0]      o_sel,
  input  logic            o_stall,
  input  logic            o_ack,
  input  logic            o_err,
  output logic [NM-1:0]   grant
);

  localparam int IW = $clog2(NM);

  if (NM < 2 || NM > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("wb_rr_arbiter: NM must be 2..8 and TIMEOUT at least 1");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;
`else
  typedef enum logic [0:0] {IDLE, OWN} state_t;
`endif

  state_t          state_q, state_d;
  logic [NM-1:0]   grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      outstanding, cnt_d;

  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [IW-1:0]   cand;
  logic            owner_cyc;
  logic            owner_stb;
  logic            inc;
  logic            dec;
  logic            abort_err;

  // Round-robin search starting just after the most recent owner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NM; k++) begin
      cand = IW'((int'(last_q) + k) % NM);
      if (!pick_vld && m_cyc[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // grant is all-zero outside OWN, so AND-OR muxing yields zeros when idle.
  assign owner_cyc = |(grant & m_cyc);
  assign owner_stb = |(grant & m_stb);
  assign o_we      = |(grant & m_we);

  always_comb begin
    o_addr = '0;
    o_data = '0;
    o_sel  = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant[i]) begin
        o_addr = o_addr | m_addr[32*i +: 32];
        o_data = o_data | m_data[32*i +: 32];
        o_sel  = o_sel  | m_sel[4*i +: 4];
      end
    end
  end

  assign o_cyc   = (state_q == OWN) & owner_cyc;
  assign o_stb   = o_cyc & owner_stb;
  assign m_stall = ~grant | (grant & {NM{o_stall}});
  assign m_ack   = grant & {NM{o_ack}};
  assign m_err   = grant & {NM{o_err | abort_err}};

  assign inc = o_stb & ~o_stall;
  assign dec = o_ack | o_err;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;

  assign abort_err = (state_q == OWN) && (timer_q == TW'(TIMEOUT));
`else
  assign abort_err = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    last_d  = last_q;
    cnt_d   = outstanding;
`ifdef WB_ARB_TIMEOUT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_vld) begin
          state_d       = OWN;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          last_d        = pick;
        end
      end
      OWN: begin
`ifdef WB_ARB_TIMEOUT_EN
        if (abort_err) begin
          state_d = ABORT;
          grant_d = '0;
          cnt_d   = '0;
          timer_d = '0;
        end else
`endif
        if (!owner_cyc) begin
          // No regrant on this edge: owners are always separated by an idle cycle.
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
`ifdef WB_ARB_TIMEOUT_EN
          timer_d = '0;
`endif
        end else begin
          if (inc && !dec && outstanding != 8'hFF) begin
            cnt_d = outstanding + 8'd1;
          end else if (dec && !inc && outstanding != 8'h00) begin
            cnt_d = outstanding - 8'd1;
          end
`ifdef WB_ARB_TIMEOUT_EN
          if (dec) begin
            timer_d = '0;
          end else if (outstanding != 8'h00) begin
            timer_d = timer_q + 1'b1;
          end
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      grant       <= '0;
      last_q      <= IW'(NM - 1);
      outstanding <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      last_q      <= last_d;
      outstanding <= cnt_d;
`ifdef WB_ARB_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed vector table, hand-written
// reset/saturation/timeout sequences, then randomized traffic against a model.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int TO = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NM-1:0]   m_cyc, m_stb, m_we;
  logic [32*NM-1:0] m_addr, m_data;
  logic [4*NM-1:0] m_sel;
  logic [NM-1:0]   m_stall, m_ack, m_err;
  logic            o_cyc, o_stb, o_we;
  logic [31:0]     o_addr, o_data;
  logic [3:0]      o_sel;
  logic            o_stall, o_ack, o_err;
  logic [NM-1:0]   grant;

  always #5 CLK = ~CLK;

  wb_rr_arbiter #(.NM(NM), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_addr(m_addr), .m_data(m_data), .m_sel(m_sel),
    .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
    .o_addr(o_addr), .o_data(o_data), .o_sel(o_sel),
    .o_stall(o_stall), .o_ack(o_ack), .o_err(o_err),
    .grant(grant)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct packed {
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       stall;
    logic       ack;
    logic [3:0] e_grant;
    logic       e_cyc;
    logic       e_stb;
    logic [3:0] e_stall;
    logic [3:0] e_ack;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [31:0] dir_addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h10;
  endfunction

  // ---------------- behavioural reference model ----------------
  int md_busy, md_abort, md_owner, md_last, md_cnt, md_timer;

  function automatic logic [127:0] pack(
      input logic [3:0] g, input logic c, input logic s, input logic we,
      input logic [3:0] sl, input logic [3:0] st, input logic [3:0] ak,
      input logic [3:0] er, input logic [31:0] a, input logic [31:0] d,
      input logic [7:0] cnt);
    return {33'd0, g, c, s, we, sl, st, ak, er, a, d, cnt};
  endfunction

  function automatic logic model_hit();
`ifdef WB_ARB_TIMEOUT_EN
    return (md_busy != 0) && (md_timer >= TO);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    md_busy = 0; md_abort = 0; md_owner = 0;
    md_last = NM - 1; md_cnt = 0; md_timer = 0;
  endtask

  task automatic model_expect(output logic [127:0] e);
    logic [3:0] g, st, ak, er, sl;
    logic c, s, we;
    logic [31:0] a, d;
    g = '0; st = 4'hF; ak = '0; er = '0; sl = '0;
    c = 1'b0; s = 1'b0; we = 1'b0; a = '0; d = '0;
    if (md_busy != 0) begin
      g[md_owner]  = 1'b1;
      c            = m_cyc[md_owner];
      s            = c && m_stb[md_owner];
      we           = m_we[md_owner];
      a            = m_addr[md_owner*32 +: 32];
      d            = m_data[md_owner*32 +: 32];
      sl           = m_sel[md_owner*4 +: 4];
      st[md_owner] = o_stall;
      ak[md_owner] = o_ack;
      er[md_owner] = o_err || model_hit();
    end
    e = pack(g, c, s, we, sl, st, ak, er, a, d, 8'(md_cnt));
  endtask

  task automatic model_step();
    int  old;
    bit  inc, dec, found;
    if (md_abort != 0) begin
      md_abort = 0;
    end else if (md_busy == 0) begin
      found = 0;
      for (int k = 1; k <= NM; k++) begin
        int idx;
        idx = (md_last + k) % NM;
        if (!found && m_cyc[idx]) begin
          found = 1; md_busy = 1; md_owner = idx; md_last = idx;
        end
      end
      md_cnt = 0; md_timer = 0;
    end else if (model_hit()) begin
      md_busy = 0; md_abort = 1; md_cnt = 0; md_timer = 0;
    end else if (!m_cyc[md_owner]) begin
      md_busy = 0; md_cnt = 0; md_timer = 0;
    end else begin
      inc = m_stb[md_owner] && !o_stall;
      dec = o_ack || o_err;
      old = md_cnt;
      if (inc && !dec) md_cnt = (md_cnt < 255) ? md_cnt + 1 : 255;
      else if (dec && !inc) md_cnt = (md_cnt > 0) ? md_cnt - 1 : 0;
      if (dec) md_timer = 0;
      else if (old > 0) md_timer = md_timer + 1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] exp_b, act_b;
    logic [31:0]  exp_a;
    logic [3:0]   cyc_r;
    int           err_cnt, err_n;
    logic [3:0]   obs_grant[12];
    logic         obs_cyc[12];
    logic [7:0]   obs_cnt[12];

    vecs[0]  = '{4'b0110, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 8'd0};
    vecs[1]  = '{4'b0110, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b1101, 4'b0000, 8'd0};
    vecs[2]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b1101, 4'b0000, 8'd0};
    vecs[3]  = '{4'b0110, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 8'd0};
    vecs[4]  = '{4'b0110, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b1011, 4'b0000, 8'd0};
    vecs[5]  = '{4'b0110, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b1011, 4'b0000, 8'd1};
    vecs[6]  = '{4'b0110, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b1011, 4'b0000, 8'd2};
    vecs[7]  = '{4'b0110, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b1011, 4'b0100, 8'd3};
    vecs[8]  = '{4'b0110, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b1011, 4'b0100, 8'd2};
    vecs[9]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b1011, 4'b0000, 8'd1};
    vecs[10] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 8'd0};
    vecs[11] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b1101, 4'b0010, 8'd0};
    vecs[12] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b1101, 4'b0000, 8'd0};
    vecs[13] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b1101, 4'b0000, 8'd1};
    vecs[14] = '{4'b0010, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b1101, 4'b0010, 8'd2};
    vecs[15] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b1101, 4'b0000, 8'd2};
    vecs[16] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b1111, 4'b0000, 8'd3};

    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '1;
    o_stall = 1'b0; o_ack = 1'b0; o_err = 1'b0;
    for (int i = 0; i < NM; i++) begin
      m_addr[32*i +: 32] = dir_addr(i);
      m_data[32*i +: 32] = 32'hD000_0000 + 32'(i);
    end

    // Reset state
    RST = 1'b1;
    #12;
    check("reset grant", 128'(grant), 128'(4'b0000));
    check("reset o_cyc", 128'({o_cyc, o_stb}), 128'(2'b00));
    check("reset stall", 128'(m_stall), 128'(4'b1111));
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Directed vector table: arbitration, handover gap, counter rules
    for (int i = 0; i < 17; i++) begin
      m_cyc = vecs[i].cyc; m_stb = vecs[i].stb;
      o_stall = vecs[i].stall; o_ack = vecs[i].ack; o_err = 1'b0;
      #2;
      exp_a = '0;
      for (int j = 0; j < NM; j++) if (vecs[i].e_grant[j]) exp_a = dir_addr(j);
      check($sformatf("v%0d grant", i), 128'(grant), 128'(vecs[i].e_grant));
      check($sformatf("v%0d cyc/stb", i), 128'({o_cyc, o_stb}), 128'({vecs[i].e_cyc, vecs[i].e_stb}));
      check($sformatf("v%0d m_stall", i), 128'(m_stall), 128'(vecs[i].e_stall));
      check($sformatf("v%0d m_ack/err", i), 128'({m_ack, m_err}), 128'({vecs[i].e_ack, 4'b0000}));
      check($sformatf("v%0d counter", i), 128'(dut.outstanding), 128'(vecs[i].e_cnt));
      check($sformatf("v%0d o_addr", i), 128'(o_addr), 128'(exp_a));
      tick();
    end

    // Asynchronous reset in the middle of an owned cycle with counter=3
    m_cyc = 4'b0010; m_stb = 4'b0010; o_stall = 1'b0; o_ack = 1'b1; o_err = 1'b1;
    #2;
    check("pre-rst counter", 128'(dut.outstanding), 128'(8'd3));
    RST = 1'b1;
    #1;
    check("rst o_cyc/stb", 128'({o_cyc, o_stb}), 128'(2'b00));
    check("rst grant", 128'(grant), 128'(4'b0000));
    check("rst m_ack/err", 128'({m_ack, m_err}), 128'(8'h00));
    check("rst counter", 128'(dut.outstanding), 128'(8'd0));
    #2;
    RST = 1'b0; o_ack = 1'b0; o_err = 1'b0; m_stb = 4'b0000;
    tick();
    check("post-rst grant", 128'(grant), 128'(4'b0010));

`ifndef WB_ARB_TIMEOUT_EN
    // Counter saturation at 255 and a single ack afterwards
    m_stb = 4'b0010;
    repeat (257) tick();
    check("sat counter", 128'(dut.outstanding), 128'(8'd255));
    m_stb = 4'b0000; o_ack = 1'b1;
    tick();
    o_ack = 1'b0;
    check("sat ack counter", 128'(dut.outstanding), 128'(8'd254));
`else
    // Hung slave: error pulse, one ABORT cycle, then IDLE
    m_cyc = 4'b0000;
    tick();
    m_cyc = 4'b0001;
    tick();
    check("to grant", 128'(grant), 128'(4'b0001));
    m_stb = 4'b0001;
    tick();
    m_stb = 4'b0000;
    err_cnt = 0; err_n = -1;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (m_err != 4'b0000) begin
        err_cnt++;
        err_n = n;
      end
      obs_grant[n] = grant; obs_cyc[n] = o_cyc; obs_cnt[n] = dut.outstanding;
      tick();
    end
    check("to err count", 128'(err_cnt), 128'(1));
    check("to err cycle", 128'(err_n), 128'(8));
    check("to abort cyc/grant", 128'({obs_cyc[9], obs_grant[9]}), 128'(5'b0_0000));
    check("to idle grant/cnt", 128'({obs_grant[10], obs_cnt[10]}), 128'({4'b0000, 8'd0}));
    check("to regrant", 128'(obs_grant[11]), 128'(4'b0001));
`endif
    m_cyc = 4'b0000;
    tick();

    // Randomized traffic against the reference model
    RST = 1'b1;
    #4;
    RST = 1'b0;
    model_reset();
    tick();
    cyc_r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NM; i++) if ($urandom_range(7) == 0) cyc_r[i] = ~cyc_r[i];
      m_cyc = cyc_r;
      m_stb = 4'($urandom);
      m_we  = 4'($urandom);
      m_sel = 16'($urandom);
      for (int i = 0; i < NM; i++) begin
        m_addr[32*i +: 32] = $urandom;
        m_data[32*i +: 32] = $urandom;
      end
      o_stall = ($urandom_range(3) == 0);
      o_ack   = ($urandom_range(9) < 3);
      o_err   = ($urandom_range(19) == 0);
      #2;
      model_expect(exp_b);
      act_b = pack(grant, o_cyc, o_stb, o_we, o_sel, m_stall, m_ack, m_err,
                   o_addr, o_data, dut.outstanding);
      check($sformatf("rand c%0d", c), act_b, exp_b);
      model_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
